// File: rtl/hamming_enc_scheduler.sv
// Round-robin front end that shares one serial Hamming(7,4) encoder among N requesters:
// grants one, shifts its nibble in LSB first, waits for ready and returns the tagged codeword.
module hamming_enc_scheduler #(
  parameter int N       = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [4*N-1:0]  req_data,
  output logic [N-1:0]    grant,
  output logic            busy,
  output logic            done,
  output logic [ID_W-1:0] done_id,
  output logic [6:0]      codeword,
  output logic            error,
  output logic            enc_data_in,
  output logic            enc_write,
  input  logic            enc_ready,
  input  logic [6:0]      enc_data_out
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT, S_DONE} state_t;

  state_t          state;
  logic [ID_W-1:0] ptr, id;
  logic [3:0]      nib;
  logic [1:0]      cnt;
  logic [TW-1:0]   timer;

  logic            found;
  logic [ID_W-1:0] sel;
  logic [N-1:0]    sel_oh;
  logic [3:0]      sel_nib;

  // Second pass (indices above ptr) overrides the wrap-around pass; descending
  // loops leave the lowest matching index, giving a rotating priority from ptr+1.
  always_comb begin
    found   = 1'b0;
    sel     = '0;
    sel_oh  = '0;
    sel_nib = '0;
    for (int i = N-1; i >= 0; i--)
      if (req[i] && i <= int'(ptr)) begin
        found   = 1'b1;
        sel     = ID_W'(i);
        sel_oh  = '0;
        sel_oh[i] = 1'b1;
        sel_nib = req_data[4*i +: 4];
      end
    for (int i = N-1; i >= 0; i--)
      if (req[i] && i > int'(ptr)) begin
        found   = 1'b1;
        sel     = ID_W'(i);
        sel_oh  = '0;
        sel_oh[i] = 1'b1;
        sel_nib = req_data[4*i +: 4];
      end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= ID_W'(N-1);
      id          <= '0;
      nib         <= '0;
      cnt         <= '0;
      timer       <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_id     <= '0;
      codeword    <= '0;
      error       <= 1'b0;
      enc_data_in <= 1'b0;
      enc_write   <= 1'b0;
    end else begin
      grant <= '0;
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            // first serial bit goes out together with the grant pulse
            grant       <= sel_oh;
            nib         <= sel_nib;
            id          <= sel;
            ptr         <= sel;
            cnt         <= '0;
            enc_write   <= 1'b1;
            enc_data_in <= sel_nib[0];
            busy        <= 1'b1;
            state       <= S_SHIFT;
          end else begin
            enc_write   <= 1'b0;
            enc_data_in <= 1'b0;
            busy        <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (cnt == 2'd3) begin
            enc_write   <= 1'b0;
            enc_data_in <= 1'b0;
            timer       <= '0;
            state       <= S_WAIT;
          end else begin
            cnt         <= cnt + 2'd1;
            enc_data_in <= nib[cnt + 2'd1];
          end
        end
        S_WAIT: begin
          if (enc_ready) begin
            codeword <= enc_data_out;
            done     <= 1'b1;
            done_id  <= id;
            state    <= S_DONE;
          end else if (timer == TW'(TIMEOUT-1)) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy        <= 1'b0;
          enc_write   <= 1'b0;
          enc_data_in <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_enc_scheduler.sv
// Directed bench for hamming_enc_scheduler: the bench plays the encoder by hand,
// scripting enc_ready per cycle and checking every output against hand-derived values.
module tb_hamming_enc_scheduler;
  localparam int N       = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [4*N-1:0]  req_data;
  logic [N-1:0]    grant;
  logic            busy, done, error, enc_data_in, enc_write, enc_ready;
  logic [ID_W-1:0] done_id;
  logic [6:0]      codeword, enc_data_out;

  int         checks = 0;
  int         errors = 0;
  logic [6:0] last_cw;

  hamming_enc_scheduler #(.N(N), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .busy(busy), .done(done), .done_id(done_id),
    .codeword(codeword), .error(error), .enc_data_in(enc_data_in),
    .enc_write(enc_write), .enc_ready(enc_ready), .enc_data_out(enc_data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset        = 1'b1;
    req          = '0;
    enc_ready    = 1'b0;
    enc_data_out = '0;
    tick;
    tick;
    chk("rst_grant",    32'(grant),       0);
    chk("rst_busy",     32'(busy),        0);
    chk("rst_done",     32'(done),        0);
    chk("rst_done_id",  32'(done_id),     0);
    chk("rst_codeword", 32'(codeword),    0);
    chk("rst_error",    32'(error),       0);
    chk("rst_enc_wr",   32'(enc_write),   0);
    chk("rst_enc_din",  32'(enc_data_in), 0);
    reset   = 1'b0;
    last_cw = '0;
  endtask

  // One full transaction starting from IDLE. rdy_dly < 0 means the encoder never answers.
  task automatic run_txn(input int id, input logic [3:0] nib, input int rdy_dly,
                         input bit spur, input logic [6:0] cw);
    logic [N-1:0] oh;
    oh = N'(1) << id;
    enc_data_out = 7'h7F;
    tick;
    chk("grant",    32'(grant),       32'(oh));
    chk("busy_g",   32'(busy),        1);
    chk("wr0",      32'(enc_write),   1);
    chk("bit0",     32'(enc_data_in), 32'(nib[0]));
    chk("err_clr",  32'(error),       0);
    for (int i = 1; i < 4; i++) begin
      enc_ready = spur && (i == 2);
      tick;
      chk("grant_pulse", 32'(grant),       0);
      chk("wr",          32'(enc_write),   1);
      chk("bit",         32'(enc_data_in), 32'(nib[i]));
      chk("done_shift",  32'(done),        0);
    end
    enc_ready    = 1'b0;
    enc_data_out = cw;
    tick;
    chk("wr_wait",  32'(enc_write),   0);
    chk("din_wait", 32'(enc_data_in), 0);
    chk("busy_w",   32'(busy),        1);
    chk("cw_hold",  32'(codeword),    32'(last_cw));
    if (rdy_dly < 0) begin
      for (int k = 0; k < TIMEOUT-1; k++) begin
        tick;
        chk("err_early", 32'(error), 0);
        chk("done_to",   32'(done),  0);
      end
      tick;
      chk("err_pulse", 32'(error),    1);
      chk("done_to",   32'(done),     0);
      chk("busy_to",   32'(busy),     0);
      chk("cw_to",     32'(codeword), 32'(last_cw));
    end else begin
      for (int k = 0; k < rdy_dly; k++) begin
        tick;
        chk("done_wait", 32'(done),  0);
        chk("err_wait",  32'(error), 0);
      end
      enc_ready = 1'b1;
      tick;
      enc_ready = 1'b0;
      chk("done",     32'(done),     1);
      chk("done_id",  32'(done_id),  id);
      chk("codeword", 32'(codeword), 32'(cw));
      chk("err_rdy",  32'(error),    0);
      last_cw = cw;
      tick;
      chk("done_off", 32'(done), 0);
      chk("busy_off", 32'(busy), 0);
    end
  endtask

  initial begin
    req_data = 16'h9C6B;  // nibbles: id0=B, id1=6, id2=C, id3=9
    do_reset;

    // single request, nibble 1011 goes out as 1,1,0,1
    req = 4'b0001;
    run_txn(0, 4'hB, 0, 1'b0, 7'b1010101);
    req = '0;
    tick;
    chk("idle_busy",  32'(busy),      0);
    chk("idle_grant", 32'(grant),     0);
    chk("idle_wr",    32'(enc_write), 0);

    // reset in the middle of SHIFT
    req = 4'b0001;
    tick;
    chk("pre_rst_grant", 32'(grant), 1);
    tick;
    reset = 1'b1;
    #1;
    chk("mid_rst_wr",   32'(enc_write), 0);
    chk("mid_rst_busy", 32'(busy),      0);
    chk("mid_rst_gnt",  32'(grant),     0);
    chk("mid_rst_done", 32'(done),      0);
    chk("mid_rst_cw",   32'(codeword),  0);
    tick;
    reset   = 1'b0;
    last_cw = '0;
    req     = 4'b0110;
    run_txn(1, 4'h6, 0, 1'b0, 7'h33);

    // round robin from a fresh reset
    do_reset;
    req = 4'b1111;
    run_txn(0, 4'hB, 0, 1'b0, 7'h11);
    run_txn(1, 4'h6, 0, 1'b0, 7'h22);
    run_txn(2, 4'hC, 0, 1'b0, 7'h44);
    run_txn(3, 4'h9, 0, 1'b0, 7'h08);
    run_txn(0, 4'hB, 0, 1'b0, 7'h5A);
    run_txn(1, 4'h6, 0, 1'b0, 7'h65);
    req = 4'b1010;
    run_txn(3, 4'h9, 0, 1'b0, 7'h0F);
    run_txn(1, 4'h6, 0, 1'b0, 7'h70);

    // timeout, then a normal grant afterwards
    req = 4'b0100;
    run_txn(2, 4'hC, -1, 1'b0, 7'h2A);
    req = 4'b1000;
    run_txn(3, 4'h9, 0, 1'b0, 7'h4C);

    // spurious ready during SHIFT
    req = 4'b0001;
    run_txn(0, 4'hB, 0, 1'b1, 7'h19);

    // ready on the last WAIT cycle beats the timeout
    req = 4'b0010;
    run_txn(1, 4'h6, TIMEOUT-1, 1'b0, 7'h66);
    req = '0;
    tick;
    chk("final_err",  32'(error), 0);
    chk("final_busy", 32'(busy),  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
